// File: rtl/pc_ctrl.sv
// pc_ctrl: program-run sequencer for a simple core. Decodes branch and
// halt instructions, looks up branch offsets in a small writable table,
// and issues single-cycle branch strobes to the program counter. The
// instruction behind each taken branch is marked as a shadow slot.
module pc_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              init,
    input  logic              start,
    input  logic [8:0]        instr,
    input  logic              zero_flag,
    input  logic              halt,
    input  logic              lut_we,
    input  logic [3:0]        lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    output logic              pc_init,
    output logic              branch_en,
    output logic [DATA_W-1:0] branch_val,
    output logic              squash,
    output logic              busy,
    output logic              done,
    output logic [7:0]        taken_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] OP_BNZ = 5'b11100;
    localparam logic [4:0] OP_BZ  = 5'b11101;
    localparam logic [4:0] OP_JMP = 5'b11110;
    localparam logic [8:0] INSTR_HALT = 9'h1FF;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] lut [16];

    // Stage p1: registered branch strobe and its offset
    logic              vld_p1;
    logic [DATA_W-1:0] bval_p1;
    logic [7:0]        cnt;

    logic exec;
    logic stop;
    logic br_cond;
    logic br_taken;

    // Count of taken branches holds at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Decode the current instruction; a shadow slot decodes nothing, and
    // any halt request in the same cycle suppresses a taken branch.
    always_comb begin
        exec    = (state == S_RUN) && !vld_p1;
        stop    = (state == S_RUN) && (halt || (exec && (instr == INSTR_HALT)));
        br_cond = 1'b0;
        case (instr[8:4])
            OP_BNZ:  br_cond = !zero_flag;
            OP_BZ:   br_cond = zero_flag;
            OP_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
        br_taken = exec && !stop && br_cond;
    end

    // Next-state selection; start only matters in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_INIT;
            S_INIT:  state_nxt = S_RUN;
            S_RUN:   if (stop) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_INIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (init) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Offset table; a same-edge write and capture sees the old entry.
    always_ff @(posedge CLK) begin
        if (init) begin
            for (int i = 0; i < 16; i++) lut[i] <= '0;
        end else if (lut_we) begin
            lut[lut_addr] <= lut_data;
        end
    end

    // Branch strobe pipeline: one-cycle pulse with offset, zero otherwise.
    always_ff @(posedge CLK) begin
        if (init) begin
            vld_p1  <= 1'b0;
            bval_p1 <= '0;
        end else begin
            vld_p1  <= br_taken;
            bval_p1 <= br_taken ? lut[instr[3:0]] : '0;
        end
    end

    // Taken-branch counter, cleared on entry to INIT.
    always_ff @(posedge CLK) begin
        if (init)                      cnt <= 8'h00;
        else if (state_nxt == S_INIT)  cnt <= 8'h00;
        else if (br_taken)             cnt <= sat_inc(cnt);
    end

    assign pc_init    = (state == S_INIT);
    assign busy       = (state == S_INIT) || (state == S_RUN);
    assign done       = (state == S_DONE);
    assign branch_en  = vld_p1;
    assign squash     = vld_p1;
    assign branch_val = bval_p1;
    assign taken_cnt  = cnt;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: the driver pushes the outputs expected
// after each clock edge, and a monitor pops and compares once per cycle.
module tb_pc_ctrl;

    logic       CLK = 1'b0;
    logic       init = 1'b0, start = 1'b0, zero_flag = 1'b0, halt = 1'b0, lut_we = 1'b0;
    logic [8:0] instr = 9'h000;
    logic [3:0] lut_addr = 4'h0;
    logic [7:0] lut_data = 8'h00;
    logic       pc_init, branch_en, squash, busy, done;
    logic [7:0] branch_val, taken_cnt;

    always #5 CLK = ~CLK;

    pc_ctrl dut (
        .CLK(CLK), .init(init), .start(start), .instr(instr),
        .zero_flag(zero_flag), .halt(halt), .lut_we(lut_we),
        .lut_addr(lut_addr), .lut_data(lut_data), .pc_init(pc_init),
        .branch_en(branch_en), .branch_val(branch_val), .squash(squash),
        .busy(busy), .done(done), .taken_cnt(taken_cnt)
    );

    // Reference model: run phase name, offset table, pending branch, count
    string      m_phase = "idle";
    logic [7:0] m_lut [16];
    bit         m_pend = 0;
    logic [7:0] m_off = 8'h00;
    int         m_cnt = 0;

    logic [20:0] exp_q [$];
    string       tag_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    // Advance the model by one clock edge and queue the expected outputs.
    task automatic model_step(input string tag);
        logic [7:0] old_val;
        bit executing, halting, taken;
        int op;
        old_val = m_lut[instr[3:0]];
        if (init) begin
            m_phase = "idle"; m_pend = 0; m_off = 0; m_cnt = 0;
            for (int i = 0; i < 16; i++) m_lut[i] = 8'h00;
        end else begin
            if (m_phase == "idle" || m_phase == "done") begin
                m_pend = 0;
                if (start) begin m_phase = "init"; m_cnt = 0; end
            end else if (m_phase == "init") begin
                m_pend = 0; m_phase = "run";
            end else begin
                executing = !m_pend;
                halting = halt || (executing && instr == 9'h1FF);
                op = int'(instr >> 4);
                taken = executing && ((op == 28 && !zero_flag) || (op == 29 && zero_flag) || op == 30);
                if (halting) begin
                    m_phase = "done"; m_pend = 0;
                end else if (taken) begin
                    m_pend = 1; m_off = old_val;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    m_pend = 0;
                end
            end
            if (lut_we) m_lut[lut_addr] = lut_data;
        end
        exp_q.push_back({m_phase == "init", m_pend, m_pend ? m_off : 8'h00, m_pend,
                         m_phase == "init" || m_phase == "run", m_phase == "done", 8'(m_cnt)});
        tag_q.push_back(tag);
    endtask

    task automatic drive(input bit i_init, input bit i_start, input logic [8:0] i_instr,
                         input bit i_z, input bit i_halt, input bit i_we,
                         input logic [3:0] i_addr, input logic [7:0] i_data, input string tag);
        @(negedge CLK);
        #1;
        init = i_init; start = i_start; instr = i_instr; zero_flag = i_z;
        halt = i_halt; lut_we = i_we; lut_addr = i_addr; lut_data = i_data;
        model_step(tag);
    endtask

    task automatic nop(input string tag);
        drive(0, 0, 9'h000, 0, 0, 0, 4'h0, 8'h00, tag);
    endtask

    // Monitor: one comparison per cycle once expectations are queued.
    initial begin
        logic [20:0] e, a;
        string t;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {pc_init, branch_en, branch_val, squash, busy, done, taken_cnt};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL %s: got pc_init=%b br_en=%b br_val=%h squash=%b busy=%b done=%b cnt=%h, expected pc_init=%b br_en=%b br_val=%h squash=%b busy=%b done=%b cnt=%h",
                             t, a[20], a[19], a[18:11], a[10], a[9], a[8], a[7:0],
                             e[20], e[19], e[18:11], e[10], e[9], e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) m_lut[i] = 8'h00;
        drive(1, 0, 9'h000, 0, 0, 0, 4'h0, 8'h00, "reset");
        drive(1, 1, 9'h1E3, 0, 0, 1, 4'h3, 8'hAA, "reset_prio");
        nop("idle");
        drive(0, 0, 9'h000, 0, 0, 1, 4'h3, 8'h05, "lut_wr3");
        drive(0, 0, 9'h000, 0, 0, 1, 4'h0, 8'h2A, "lut_wr0");
        drive(0, 1, 9'h000, 0, 0, 0, 4'h0, 8'h00, "start");
        drive(0, 1, 9'h000, 0, 0, 0, 4'h0, 8'h00, "init_cycle");
        drive(0, 0, 9'h1E3, 0, 0, 0, 4'h0, 8'h00, "jmp3");
        drive(0, 1, 9'h1FF, 0, 0, 0, 4'h0, 8'h00, "halt_in_shadow");
        drive(0, 0, 9'h1C0, 1, 0, 0, 4'h0, 8'h00, "bnz_not_taken");
        drive(0, 0, 9'h1C0, 0, 0, 0, 4'h0, 8'h00, "bnz_taken");
        nop("shadow");
        drive(0, 0, 9'h1FF, 0, 0, 0, 4'h0, 8'h00, "halt_instr");
        nop("done_hold");
        drive(0, 1, 9'h000, 0, 0, 0, 4'h0, 8'h00, "restart");
        nop("init2");
        drive(0, 0, 9'h1D3, 1, 1, 0, 4'h0, 8'h00, "halt_vs_bz");
        nop("done2");
        drive(0, 1, 9'h000, 0, 0, 0, 4'h0, 8'h00, "restart3");
        nop("init3");
        drive(0, 0, 9'h1E5, 0, 0, 1, 4'h5, 8'h77, "same_edge_wr");
        drive(0, 0, 9'h000, 0, 1, 0, 4'h0, 8'h00, "halt_on_pulse");
        nop("done3");
        drive(0, 1, 9'h000, 0, 0, 0, 4'h0, 8'h00, "restart4");
        nop("init4");
        for (int i = 0; i < 600; i++) drive(0, 0, 9'h1E5, 0, 0, 0, 4'h0, 8'h00, "sat_run");
        drive(0, 0, 9'h1FF, 0, 0, 0, 4'h0, 8'h00, "sat_halt_a");
        drive(0, 0, 9'h1FF, 0, 0, 0, 4'h0, 8'h00, "sat_halt_b");
        drive(0, 1, 9'h000, 0, 0, 0, 4'h0, 8'h00, "sat_restart");
        nop("sat_init");
        drive(0, 0, 9'h1E3, 0, 0, 0, 4'h0, 8'h00, "pend_jmp");
        drive(1, 1, 9'h000, 0, 0, 1, 4'h1, 8'h11, "mid_run_init");
        drive(0, 1, 9'h000, 0, 0, 0, 4'h0, 8'h00, "post_init_start");
        nop("post_init_init");
        drive(0, 0, 9'h1E3, 0, 0, 0, 4'h0, 8'h00, "lut_cleared");
        nop("lut_cleared_pulse");
        for (int i = 0; i < 2000; i++) begin
            logic [8:0] ins;
            int r;
            r = $urandom_range(0, 7);
            if (r < 3)       ins = {5'(5'd28 + r), 4'($urandom_range(0, 15))};
            else if (r == 3) ins = 9'h1FF;
            else             ins = 9'($urandom);
            if (r == 3 && $urandom_range(0, 3) != 0) ins = 9'h1E0 | 9'($urandom_range(0, 15));
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, ins,
                  1'($urandom), $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                  4'($urandom), 8'($urandom), "random");
        end
        nop("drain");
        @(negedge CLK);
        @(negedge CLK);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
